regfile_writer: RTL and testbench



---
 rtl/regfile_writer.sv | 54 +++++
 tb/tb_regfile_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
// regfile_writer: write port, storage and bulk-clear sweep of the 32x32 register file
module regfile_writer (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [4:0]    wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [31:0]   wr_onehot,
  output logic [1023:0] reg_flat
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [4:0] idx, idx_nx;
  logic [31:0] en, wdat;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    en = '0;
    wdat = wr_data;
    if (state == IDLE) begin
      en = (wr_valid && wr_addr != 5'd0) ? 32'd1 << wr_addr : '0;
      state_nx = clr_start ? CLEAR : IDLE;
      idx_nx = clr_start ? 5'd1 : idx;
    end else begin
      en = 32'd1 << idx;
      wdat = '0;
      state_nx = (idx == 5'd31) ? IDLE : CLEAR;
      idx_nx = (idx == 5'd31) ? idx : idx + 5'd1;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      wr_onehot <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      wr_onehot <= en;
    end
  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign reg_flat[31:0] = '0;
  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (en[g]) q <= wdat;
    assign reg_flat[32*g +: 32] = q;
  end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed stimulus with a commit scoreboard checked by a negedge monitor
module tb_regfile_writer;
  logic clock = 1'b0;
  logic reset_n, wr_valid, clr_start;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic wr_ready, clr_busy;
  logic [31:0] wr_onehot;
  logic [1023:0] reg_flat;
  int n_chk = 0, n_fail = 0;
  logic [31:0] model [32];
  typedef struct {logic [31:0] oh; int r; logic [31:0] d;} exp_t;
  exp_t q [$];
  exp_t e;

  regfile_writer dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_onehot(wr_onehot), .reg_flat(reg_flat)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_regs(input string nm);
    int bad = -1;
    n_chk++;
    for (int r = 0; r < 32; r++)
      if (bad < 0 && reg_flat[32*r +: 32] !== model[r]) bad = r;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: reg%0d got %h, required %h", nm, bad, reg_flat[32*bad +: 32], model[bad]);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int r, input logic [31:0] d);
    exp_t x;
    x.oh = 32'd1 << r;
    x.r = r;
    x.d = d;
    q.push_back(x);
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    chk("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a != 5'd0) push(int'(a), d);
    tick;
    if (a != 5'd0) model[a] = d;
    wr_valid = 1'b0;
  endtask

  task automatic chk_flags(input string nm, input logic busy);
    chk({nm, "_busy"}, {31'd0, clr_busy}, {31'd0, busy});
    chk({nm, "_ready"}, {31'd0, wr_ready}, {31'd0, ~busy});
  endtask

  // Every nonzero wr_onehot is a commit; it must match the oldest expected commit
  always @(negedge clock)
    if (reset_n && wr_onehot != 32'd0) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL onehot_unexpected: got %h, required no pulse", wr_onehot);
      end else begin
        e = q.pop_front();
        chk("onehot", wr_onehot, e.oh);
        chk("reg_after_commit", reg_flat[32*e.r +: 32], e.d);
      end
    end

  initial begin
    for (int r = 0; r < 32; r++) model[r] = '0;
    reset_n = 1'b0;
    wr_valid = 1'b0;
    clr_start = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #2;
    chk_regs("reset_regs");
    chk_flags("reset", 1'b0);
    chk("reset_onehot", wr_onehot, 32'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;

    write1(5'd5, 32'hDEADBEEF);
    chk("reg5_after_write", reg_flat[191:160], 32'hDEADBEEF);
    chk_regs("write5_regs");
    tick;
    chk("onehot_drops", wr_onehot, 32'd0);

    write1(5'd0, 32'hFFFFFFFF);
    chk("reg0_onehot", wr_onehot, 32'd0);
    chk("reg0_slice", reg_flat[31:0], 32'd0);
    chk_regs("reg0_regs");

    for (int a = 1; a < 32; a++) write1(a[4:0], 32'h100 + a);
    chk_regs("b2b_regs");

    wr_valid = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h55;
    clr_start = 1'b1;
    push(3, 32'h55);
    for (int i = 1; i < 32; i++) push(i, 32'd0);
    push(7, 32'h77);
    tick;
    model[3] = 32'h55;
    chk_regs("clr_write_first");
    clr_start = 1'b0;
    wr_addr = 5'd7;
    wr_data = 32'h77;
    for (int c = 1; c < 32; c++) begin
      chk_flags("sweep", 1'b1);
      tick;
      model[c] = '0;
    end
    chk_flags("sweep_end", 1'b0);
    chk_regs("sweep_regs");
    tick;
    model[7] = 32'h77;
    wr_valid = 1'b0;
    chk_regs("held_write_after_sweep");

    write1(5'd30, 32'hA5A5A5A5);
    write1(5'd2, 32'h1234);
    clr_start = 1'b1;
    for (int i = 1; i < 10; i++) push(i, 32'd0);
    tick;
    clr_start = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) model[r] = '0;
    chk_regs("midsweep_reset_regs");
    chk_flags("midsweep_reset", 1'b0);
    chk("midsweep_reset_onehot", wr_onehot, 32'd0);
    tick;
    reset_n = 1'b1;
    write1(5'd20, 32'hCAFE);
    for (int c = 0; c < 3; c++) tick;
    chk("post_reset_onehot", wr_onehot, 32'd0);
    chk_flags("post_reset", 1'b0);
    chk_regs("post_reset_regs");

    write1(5'd31, 32'h31);
    clr_start = 1'b1;
    for (int i = 1; i < 32; i++) push(i, 32'd0);
    tick;
    clr_start = 1'b0;
    for (int c = 1; c < 32; c++) begin
      clr_start = (c == 20);
      chk_flags("resweep", 1'b1);
      tick;
      model[c] = '0;
    end
    clr_start = 1'b0;
    chk_flags("resweep_end", 1'b0);
    tick;
    chk_flags("resweep_no_restart", 1'b0);
    chk("resweep_onehot_idle", wr_onehot, 32'd0);
    chk_regs("resweep_regs");
    @(negedge clock);
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
